// File: rtl/graph_entry_fsm.sv
// Switch-driven graph loader: captures N, M and M (src, dst, weight) triples
// over a four-phase strobe/ack handshake and writes each edge to the edge RAM.
module graph_entry_fsm #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned MAX_NODES = 16,
  parameter int unsigned MAX_EDGES = 32,
  parameter int unsigned NODE_W    = $clog2(MAX_NODES),
  parameter int unsigned EDGE_W    = $clog2(MAX_EDGES)
) (
  input  logic              clk,
  input  logic              KEY,
  input  logic [DATA_W:0]   SW,
  output logic              LEDG,
  output logic              LEDR,
  output logic              we,
  output logic [EDGE_W-1:0] waddr,
  output logic [NODE_W-1:0] wsrc,
  output logic [NODE_W-1:0] wdst,
  output logic [DATA_W-1:0] wwt,
  output logic [NODE_W:0]   node_cnt,
  output logic [EDGE_W:0]   edge_cnt,
  output logic              done,
  output logic              start
);

  localparam int unsigned NC_W = NODE_W + 1;
  localparam int unsigned EC_W = EDGE_W + 1;

  typedef enum logic [2:0] {
    GET_N, GET_M, GET_SRC, GET_DST, GET_WT, DONE
  } state_t;

  logic rst_n;
  assign rst_n = KEY;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              ledg_q, ledg_d;
  logic              ledr_q, ledr_d;
  logic              ok_q, ok_d;
  logic              we_q, we_d;
  logic [EDGE_W-1:0] waddr_q, waddr_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [NODE_W-1:0] dst_q, dst_d;
  logic [NODE_W-1:0] wsrc_q, wsrc_d;
  logic [NODE_W-1:0] wdst_q, wdst_d;
  logic [DATA_W-1:0] wwt_q, wwt_d;
  logic [NC_W-1:0]   node_cnt_q, node_cnt_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [EC_W-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              start_q, start_d;

  logic        rise, fall;
  int unsigned data_u;

  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;
  assign data_u = 32'(SW[DATA_W-1:0]);

  // Capture/validate on strobe rise, advance on strobe fall.
  always_comb begin
    state_d    = state_q;
    ledg_d     = ledg_q;
    ledr_d     = ledr_q;
    ok_d       = ok_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    wsrc_d     = wsrc_q;
    wdst_d     = wdst_q;
    wwt_d      = wwt_q;
    node_cnt_d = node_cnt_q;
    edge_cnt_d = edge_cnt_q;
    idx_d      = idx_q;
    done_d     = done_q;
    start_d    = 1'b0;

    if (state_q != DONE) begin
      if (rise) begin
        ledg_d = 1'b1;
        ok_d   = 1'b0;
        case (state_q)
          GET_N: begin
            if (data_u >= 1 && data_u <= MAX_NODES) begin
              ok_d       = 1'b1;
              node_cnt_d = NC_W'(data_u);
            end
          end
          GET_M: begin
            if (data_u <= MAX_EDGES) begin
              ok_d       = 1'b1;
              edge_cnt_d = EC_W'(data_u);
              idx_d      = '0;
            end
          end
          GET_SRC: begin
            if (data_u < 32'(node_cnt_q)) begin
              ok_d  = 1'b1;
              src_d = SW[NODE_W-1:0];
            end
          end
          GET_DST: begin
            if (data_u < 32'(node_cnt_q)) begin
              ok_d  = 1'b1;
              dst_d = SW[NODE_W-1:0];
            end
          end
          GET_WT: begin
            ok_d    = 1'b1;
            we_d    = 1'b1;
            waddr_d = idx_q[EDGE_W-1:0];
            wsrc_d  = src_q;
            wdst_d  = dst_q;
            wwt_d   = SW[DATA_W-1:0];
          end
          default: ok_d = 1'b0;
        endcase
        ledr_d = ~ok_d;
      end else if (fall && ledg_q) begin
        ledg_d = 1'b0;
        if (ok_q) begin
          case (state_q)
            GET_N:   state_d = GET_M;
            GET_M: begin
              if (edge_cnt_q == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
                start_d = 1'b1;
              end else begin
                state_d = GET_SRC;
              end
            end
            GET_SRC: state_d = GET_DST;
            GET_DST: state_d = GET_WT;
            GET_WT: begin
              idx_d = idx_q + EC_W'(1);
              if (idx_d == edge_cnt_q) begin
                state_d = DONE;
                done_d  = 1'b1;
                start_d = 1'b1;
              end else begin
                state_d = GET_SRC;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= GET_N;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      ledg_q     <= 1'b0;
      ledr_q     <= 1'b0;
      ok_q       <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      wsrc_q     <= '0;
      wdst_q     <= '0;
      wwt_q      <= '0;
      node_cnt_q <= '0;
      edge_cnt_q <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= SW[DATA_W];
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      ledg_q     <= ledg_d;
      ledr_q     <= ledr_d;
      ok_q       <= ok_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      wsrc_q     <= wsrc_d;
      wdst_q     <= wdst_d;
      wwt_q      <= wwt_d;
      node_cnt_q <= node_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      start_q    <= start_d;
    end
  end

  assign LEDG     = ledg_q;
  assign LEDR     = ledr_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wsrc     = wsrc_q;
  assign wdst     = wdst_q;
  assign wwt      = wwt_q;
  assign node_cnt = node_cnt_q;
  assign edge_cnt = edge_cnt_q;
  assign done     = done_q;
  assign start    = start_q;

endmodule
